// File: rtl/adc_serial_reader.sv
// adc_serial_reader: gates the ADC clock divider and drives the ADC chip select.
// It shifts in one conversion frame on rising edges of the divided clock, which is
// sampled as ordinary data in the clk_in domain. Each completed sample is presented
// as a parallel word together with a one-cycle valid strobe.
module adc_serial_reader #(
  parameter int FRAME_BITS = 16,
  parameter int LEAD_BITS  = 4,
  parameter int DATA_W     = 12,
  parameter int CS_SETUP   = 2,
  parameter int CS_QUIET   = 4
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              start,
  input  logic              sclk,
  input  logic              sdata,
  output logic              divider_en,
  output logic              cs_n,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_valid,
  output logic              busy,
  output logic              overrun
);

  localparam int CNT_W    = $clog2(FRAME_BITS) + 1;
  localparam int WAIT_MAX = (CS_SETUP > CS_QUIET) ? CS_SETUP : CS_QUIET;
  localparam int WAIT_W   = $clog2(WAIT_MAX) + 1;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, QUIET} state_t;

  state_t             state, state_nxt;
  logic               sclk_q;
  logic               rise;
  logic               keep_bit;
  logic               last_rise;
  logic [CNT_W-1:0]   bit_cnt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [DATA_W-1:0]  shift_p0;
  logic [DATA_W-1:0]  shift_nxt;

  // Edge detect, the data-bit window, and the next shift-register value
  always_comb begin
    rise      = sclk & ~sclk_q;
    keep_bit  = (bit_cnt >= CNT_W'(LEAD_BITS)) &&
                (bit_cnt <  CNT_W'(LEAD_BITS + DATA_W));
    last_rise = (state == SHIFT) && rise && (bit_cnt == CNT_W'(FRAME_BITS - 1));
    shift_nxt = shift_p0;
    if ((state == SHIFT) && rise && keep_bit)
      shift_nxt = {shift_p0[DATA_W-2:0], sdata};
  end

  // Next-state logic and the state-decoded outputs
  always_comb begin
    state_nxt  = state;
    cs_n       = 1'b1;
    divider_en = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE:  if (start) state_nxt = SETUP;
      SETUP: begin
        cs_n = 1'b0;
        if (wait_cnt == WAIT_W'(CS_SETUP - 1)) state_nxt = SHIFT;
      end
      SHIFT: begin
        cs_n       = 1'b0;
        divider_en = 1'b1;
        if (last_rise) state_nxt = QUIET;
      end
      QUIET: if (wait_cnt == WAIT_W'(CS_QUIET - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_in) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Control: edge history, counters, strobes and the held output word
  always_ff @(posedge clk_in) begin
    if (reset) begin
      sclk_q       <= 1'b0;
      bit_cnt      <= '0;
      wait_cnt     <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      sample_data  <= '0;
    end else begin
      sclk_q       <= sclk;
      sample_valid <= last_rise;
      overrun      <= start && (state != IDLE);
      if (state_nxt != state)
        wait_cnt <= '0;
      else if ((state == SETUP) || (state == QUIET))
        wait_cnt <= wait_cnt + 1'b1;
      if ((state_nxt == SHIFT) && (state != SHIFT))
        bit_cnt <= '0;
      else if ((state == SHIFT) && rise)
        bit_cnt <= bit_cnt + 1'b1;
      if (last_rise)
        sample_data <= shift_nxt;
    end
  end

  // Shift register starts clean every frame so no bits carry across frames
  always_ff @(posedge clk_in) begin
    if ((state_nxt == SHIFT) && (state != SHIFT))
      shift_p0 <= '0;
    else
      shift_p0 <= shift_nxt;
  end

endmodule

// File: tb/tb_adc_serial_reader.sv
// Testbench for adc_serial_reader: divide-by-4 serial clock driven by tasks,
// expected samples taken from the frame layout (lead bits dropped, MSB first).
module tb_adc_serial_reader;

  localparam int FRAME_BITS = 16;
  localparam int LEAD_BITS  = 4;
  localparam int DATA_W     = 12;
  localparam int CS_SETUP   = 2;
  localparam int CS_QUIET   = 4;

  logic              clk_in = 1'b0;
  logic              reset, start, sclk, sdata;
  logic              divider_en, cs_n, sample_valid, busy, overrun;
  logic [DATA_W-1:0] sample_data;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  adc_serial_reader #(
    .FRAME_BITS(FRAME_BITS), .LEAD_BITS(LEAD_BITS), .DATA_W(DATA_W),
    .CS_SETUP(CS_SETUP), .CS_QUIET(CS_QUIET)
  ) dut (
    .clk_in(clk_in), .reset(reset), .start(start), .sclk(sclk), .sdata(sdata),
    .divider_en(divider_en), .cs_n(cs_n), .sample_data(sample_data),
    .sample_valid(sample_valid), .busy(busy), .overrun(overrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: the kept field sits right after the lead bits, MSB first
  function automatic logic [DATA_W-1:0] ref_sample(input logic [FRAME_BITS-1:0] f);
    int v;
    v = int'(f) / (1 << (FRAME_BITS - LEAD_BITS - DATA_W));
    return DATA_W'(v % (1 << DATA_W));
  endfunction

  // Scoreboard: every strobe must match the next expected word; the output
  // word must hold its value between strobes and read zero after reset.
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] held = '0;
  int   valid_cnt = 0;
  logic rst_seen  = 1'b0;
  logic mon_on    = 1'b0;

  always @(posedge clk_in) rst_seen <= reset;

  always @(negedge clk_in) begin
    if (mon_on) begin
      if (rst_seen) held = '0;
      if (sample_valid) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got %0h expected no strobe", sample_data);
        end else begin
          held = exp_q.pop_front();
        end
      end
      chk("sample_data_hold", 32'(sample_data), 32'(held));
    end
  end

  task automatic tick();
    @(negedge clk_in);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_shift();
    int n = 0;
    while (!divider_en && n < 20) begin
      tick();
      n++;
    end
    chk("divider_en_timeout", 32'(divider_en), 32'd1);
  endtask

  // Drive nbits frame bits with sclk at clk_in/4; returns one cycle after the last rise
  task automatic run_bits(input logic [FRAME_BITS-1:0] f, input int nbits,
                          input logic full, input logic [DATA_W-1:0] exp);
    wait_shift();
    if (full) exp_q.push_back(exp);
    for (int i = 0; i < nbits; i++) begin
      sclk  = 1'b0;
      sdata = f[FRAME_BITS-1-i];
      tick();
      chk("frame_ctl", 32'({cs_n, divider_en}), 32'b01);
      tick();
      sclk = 1'b1;
      tick();
      if (i != nbits - 1) tick();
    end
    sclk = 1'b0;
  endtask

  typedef struct {
    logic [FRAME_BITS-1:0] frame;
    logic [DATA_W-1:0]     exp;
  } vec_t;

  vec_t vecs[4];
  logic [FRAME_BITS-1:0] rf;
  logic [DATA_W-1:0]     re;
  int v0;

  initial begin
    vecs[0] = '{16'h0FFF, 12'hFFF};
    vecs[1] = '{16'hC001, 12'h001};
    vecs[2] = '{16'hA000, 12'h000};
    vecs[3] = '{16'h6E4B, 12'hE4B};

    reset = 1'b1; start = 1'b0; sclk = 1'b0; sdata = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", 32'({cs_n, divider_en, sample_valid, busy, overrun}), 32'b10000);
    chk("reset_data", 32'(sample_data), 32'h0);
    reset  = 1'b0;
    mon_on = 1'b1;
    tick();

    // Basic frame with setup and quiet timing
    pulse_start();
    chk("start_cs_low", 32'({cs_n, busy, divider_en}), 32'b010);
    tick();
    chk("setup_div_off", 32'(divider_en), 32'd0);
    tick();
    chk("setup_div_on", 32'(divider_en), 32'd1);
    run_bits(16'h0AC3, FRAME_BITS, 1'b1, 12'hAC3);
    chk("end_ctl", 32'({cs_n, divider_en, sample_valid, busy}), 32'b1011);
    chk("end_data", 32'(sample_data), 32'hAC3);
    for (int q = 2; q <= CS_QUIET; q++) begin
      tick();
      chk("quiet_ctl", 32'({cs_n, sample_valid, busy}), 32'b101);
    end
    tick();
    chk("quiet_done", 32'(busy), 32'd0);

    // sclk activity outside SHIFT is ignored
    for (int i = 0; i < 6; i++) begin
      sclk  = ~sclk;
      sdata = 1'($urandom);
      tick();
    end
    sclk = 1'b0;
    chk("idle_toggle_hold", 32'(sample_data), 32'hAC3);
    chk("idle_toggle_ctl", 32'({cs_n, busy}), 32'b10);
    start = 1'b1;
    tick();
    start = 1'b0;
    sclk  = 1'b1;
    sdata = 1'b1;
    tick();
    sclk = 1'b0;
    tick();
    run_bits(16'h5A5A, FRAME_BITS, 1'b1, 12'hA5A);
    for (int i = 0; i < CS_QUIET; i++) begin
      sclk = ~sclk;
      tick();
    end
    sclk = 1'b0;
    chk("quiet_toggle_hold", 32'(sample_data), 32'hA5A);
    chk("valid_count_a", 32'(valid_cnt), 32'd2);

    // start held through a frame: overrun, one strobe, restart only from IDLE
    start = 1'b1;
    tick();
    chk("held_first", 32'({cs_n, overrun}), 32'b00);
    tick();
    chk("held_overrun", 32'(overrun), 32'd1);
    run_bits(16'hF001, FRAME_BITS, 1'b1, 12'h001);
    chk("held_end", 32'({sample_valid, busy}), 32'b11);
    repeat (CS_QUIET - 1) tick();
    chk("held_quiet", 32'({cs_n, busy}), 32'b11);
    tick();
    chk("held_idle", 32'({busy, overrun}), 32'b01);
    tick();
    chk("held_restart", 32'({cs_n, overrun}), 32'b00);
    start = 1'b0;
    run_bits(16'h3FFF, FRAME_BITS, 1'b1, 12'hFFF);
    repeat (CS_QUIET) tick();
    chk("valid_count_b", 32'(valid_cnt), 32'd4);

    // Reset after seven rises aborts the frame
    pulse_start();
    run_bits(16'hFFFF, 7, 1'b0, 12'h000);
    reset = 1'b1;
    tick();
    chk("abort_ctl", 32'({cs_n, divider_en, sample_valid, busy}), 32'b1000);
    chk("abort_data", 32'(sample_data), 32'h0);
    reset = 1'b0;
    tick();
    pulse_start();
    run_bits(16'h0AC3, FRAME_BITS, 1'b1, 12'hAC3);
    chk("after_abort", 32'(sample_data), 32'hAC3);
    repeat (CS_QUIET) tick();
    chk("valid_count_c", 32'(valid_cnt), 32'd5);

    // Back-to-back table frames
    for (int k = 0; k < 4; k++) begin
      pulse_start();
      run_bits(vecs[k].frame, FRAME_BITS, 1'b1, vecs[k].exp);
      chk("table_sample", 32'(sample_data), 32'(vecs[k].exp));
      repeat (CS_QUIET) tick();
    end

    // Randomized frames against the reference
    v0 = valid_cnt;
    for (int k = 0; k < 10; k++) begin
      rf = FRAME_BITS'($urandom);
      re = ref_sample(rf);
      pulse_start();
      run_bits(rf, FRAME_BITS, 1'b1, re);
      chk("random_sample", 32'(sample_data), 32'(re));
      repeat (CS_QUIET) tick();
    end
    chk("random_valid_count", 32'(valid_cnt - v0), 32'd10);
    chk("pending_expected", 32'(exp_q.size()), 32'd0);
    chk("valid_count_total", 32'(valid_cnt), 32'd19);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
